ascii_num_sep_ctrl: RTL and testbench

Sequencer for the ASCII number-separation datapath. Once a payload sits in the character buffer, it runs three stages in order: the payload validator, then the character-stream parser, then the ASCII-to-int32 converter. It collects each converted int32 into the number buffer through a single write port and reports done, count and error status to the top-level command FSM. It is the only block that drives the parser's start/clear and the validator's start.

---
 rtl/ascii_num_sep_pkg.sv | 29 ++
 rtl/ascii_num_sep_ctrl_if.sv | 40 ++++
 rtl/sep_result_writer.sv | 44 ++++
 rtl/ascii_num_sep_ctrl.sv | 152 +++++++++++++++
 tb/tb_ascii_num_sep_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ascii_num_sep_pkg.sv
// rtl/ascii_num_sep_pkg.sv - shared state, error-code and width definitions for the number-separation sequencer
package ascii_num_sep_pkg;

    localparam int CNT_W = 11;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_CLEAR      = 4'd1,
        ST_CHECK      = 4'd2,
        ST_VALIDATE   = 4'd3,
        ST_WAIT_VAL   = 4'd4,
        ST_PARSE      = 4'd5,
        ST_WAIT_PARSE = 4'd6,
        ST_DONE       = 4'd7,
        ST_ERROR      = 4'd8
    } sep_ctrl_state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_INVALID  = 3'd1;
    localparam logic [2:0] ERR_EMPTY    = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

    // Idle-like states accept a new packet; everything else is a packet in flight.
    function automatic logic state_is_busy(input sep_ctrl_state_t s);
        return !(s == ST_IDLE || s == ST_DONE || s == ST_ERROR);
    endfunction

endpackage

// File: rtl/ascii_num_sep_ctrl_if.sv
// rtl/ascii_num_sep_ctrl_if.sv - handshake, result-write and status bundle of the number-separation sequencer
interface ascii_num_sep_ctrl_if;
    import ascii_num_sep_pkg::*;

    logic             pkt_ready;
    logic [15:0]      pkt_length;
    logic             abort;
    logic             val_start;
    logic             val_done;
    logic             val_invalid;
    logic             parse_clear;
    logic             parse_start;
    logic [15:0]      parse_length;
    logic             parse_done;
    logic             conv_valid;
    logic [31:0]      conv_data;
    logic             wr_en;
    logic [CNT_W-1:0] wr_addr;
    logic [31:0]      wr_data;
    logic             busy;
    logic             done;
    logic             error;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] num_count;

    modport master (
        input  pkt_ready, pkt_length, abort, val_done, val_invalid,
               parse_done, conv_valid, conv_data,
        output val_start, parse_clear, parse_start, parse_length,
               wr_en, wr_addr, wr_data, busy, done, error, err_code, num_count
    );

    modport slave (
        output pkt_ready, pkt_length, abort, val_done, val_invalid,
               parse_done, conv_valid, conv_data,
        input  val_start, parse_clear, parse_start, parse_length,
               wr_en, wr_addr, wr_data, busy, done, error, err_code, num_count
    );

endinterface

// File: rtl/sep_result_writer.sv
// rtl/sep_result_writer.sv - registered number-buffer write port with result count and overflow detect
module sep_result_writer
    import ascii_num_sep_pkg::*;
#(
    parameter int MAX_NUMS = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic [31:0]      conv_data,
    output logic             overflow,
    output logic             wr_en,
    output logic [CNT_W-1:0] wr_addr,
    output logic [31:0]      wr_data,
    output logic [CNT_W-1:0] num_count
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NUMS);

    // A result arriving with the buffer already full is refused, not written.
    assign overflow = accept && (num_count == MAX_CNT);

    // Register the write one cycle after the converter strobe; clear wins over a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            num_count <= '0;
        end else begin
            wr_en <= 1'b0;
            if (clear) begin
                num_count <= '0;
            end else if (accept && !overflow) begin
                wr_en     <= 1'b1;
                wr_addr   <= num_count;
                wr_data   <= conv_data;
                num_count <= num_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ascii_num_sep_ctrl.sv
// rtl/ascii_num_sep_ctrl.sv - validate/parse/convert sequencer; optional watchdog under ASCII_SEP_TIMEOUT_EN
module ascii_num_sep_ctrl
    import ascii_num_sep_pkg::*;
#(
    parameter int MAX_NUMS       = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    ascii_num_sep_ctrl_if.master bus
);

    sep_ctrl_state_t state, next_state;
    logic [2:0]      err_q, err_next;
    logic [15:0]     len_q;
    logic            start_q;
    logic            clr_q;
    logic            accept;
    logic            overflow;
    logic            wd_expired;
    logic            timeout_hit;
    logic            pkt_accept;

    assign pkt_accept = bus.pkt_ready && !bus.abort && !state_is_busy(state);
    assign accept     = bus.conv_valid && !bus.abort && (state == ST_WAIT_PARSE);

`ifdef ASCII_SEP_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt;

    assign wd_expired = (state == ST_WAIT_VAL || state == ST_WAIT_PARSE) && (wd_cnt == WD_LAST);

    // Watchdog: counts wait-state cycles, restarting on any state change or accepted result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (next_state != state || accept) begin
            wd_cnt <= '0;
        end else if (state == ST_WAIT_VAL || state == ST_WAIT_PARSE) begin
            wd_cnt <= wd_cnt + 16'd1;
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    logic [15:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
    assign wd_expired = 1'b0;
`endif

    // Next-state and error-code selection; abort overrides everything.
    always_comb begin
        next_state  = state;
        err_next    = err_q;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.pkt_ready) begin
                    next_state = ST_CLEAR;
                    err_next   = ERR_NONE;
                end
            end
            ST_CLEAR:    next_state = ST_CHECK;
            ST_CHECK: begin
                if (len_q == 16'd0) begin
                    next_state = ST_ERROR;
                    err_next   = ERR_EMPTY;
                end else begin
                    next_state = ST_VALIDATE;
                end
            end
            ST_VALIDATE: next_state = ST_WAIT_VAL;
            ST_WAIT_VAL: begin
                if (bus.val_done) begin
                    if (bus.val_invalid) begin
                        next_state = ST_ERROR;
                        err_next   = ERR_INVALID;
                    end else begin
                        next_state = ST_PARSE;
                    end
                end else if (wd_expired) begin
                    next_state  = ST_ERROR;
                    err_next    = ERR_TIMEOUT;
                    timeout_hit = 1'b1;
                end
            end
            ST_PARSE:    next_state = ST_WAIT_PARSE;
            ST_WAIT_PARSE: begin
                if (overflow) begin
                    next_state = ST_ERROR;
                    err_next   = ERR_OVERFLOW;
                end else if (bus.parse_done) begin
                    next_state = ST_DONE;
                end else if (wd_expired && !accept) begin
                    next_state  = ST_ERROR;
                    err_next    = ERR_TIMEOUT;
                    timeout_hit = 1'b1;
                end
            end
            default:     next_state = ST_IDLE;
        endcase
        if (bus.abort) begin
            next_state  = ST_IDLE;
            err_next    = ERR_NONE;
            timeout_hit = 1'b0;
        end
    end

    // State, status and the delayed parser-control pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            err_q   <= ERR_NONE;
            len_q   <= '0;
            start_q <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state   <= next_state;
            err_q   <= err_next;
            start_q <= (state == ST_PARSE) && !bus.abort;
            clr_q   <= bus.abort || timeout_hit;
            if (pkt_accept) begin
                len_q <= bus.pkt_length;
            end
        end
    end

    sep_result_writer #(
        .MAX_NUMS (MAX_NUMS)
    ) u_writer (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.abort || state == ST_CLEAR),
        .accept    (accept),
        .conv_data (bus.conv_data),
        .overflow  (overflow),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .num_count (bus.num_count)
    );

    assign bus.val_start    = (state == ST_VALIDATE) && !bus.abort;
    assign bus.parse_start  = start_q && !bus.abort;
    assign bus.parse_clear  = (state == ST_CLEAR) || clr_q;
    assign bus.parse_length = len_q;
    assign bus.busy         = state_is_busy(state);
    assign bus.done         = (state == ST_DONE);
    assign bus.error        = (state == ST_ERROR);
    assign bus.err_code     = err_q;

endmodule

// File: tb/tb_ascii_num_sep_ctrl.sv
// tb/tb_ascii_num_sep_ctrl.sv - directed and randomized self-checking bench for ascii_num_sep_ctrl
module tb_ascii_num_sep_ctrl;

    localparam int MAX_NUMS       = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ascii_num_sep_ctrl_if bus ();

    ascii_num_sep_ctrl #(
        .MAX_NUMS       (MAX_NUMS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int vs_cnt   = 0;
    int ps_cnt   = 0;
    logic [10:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [31:0] vals[8];

    always @(negedge clk) begin
        if (bus.val_start)   vs_cnt++;
        if (bus.parse_start) ps_cnt++;
        if (bus.wr_en) begin
            wq_addr.push_back(bus.wr_addr);
            wq_data.push_back(bus.wr_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic run_packet(input int len, input bit invalid, input int nvals, input bit last_with_done);
        int vs0, ps0, wq0, exp_n, exp_err, budget;
        bit exp_done;
        vs0 = vs_cnt; ps0 = ps_cnt; wq0 = wq_addr.size();
        bus.pkt_ready = 1'b1; bus.pkt_length = len[15:0];
        tick();
        bus.pkt_ready = 1'b0;
        budget = 10;
        while (!bus.val_start && bus.busy && budget > 0) begin tick(); budget--; end
        if (bus.val_start) begin
            tick();
            repeat ($urandom_range(0, 3)) begin
                bus.pkt_ready  = 1'($urandom_range(0, 1));
                bus.pkt_length = 16'd0;
                bus.conv_valid = 1'($urandom_range(0, 1));
                bus.conv_data  = $urandom;
                tick();
            end
            bus.pkt_ready = 1'b0; bus.conv_valid = 1'b0;
            bus.val_done = 1'b1; bus.val_invalid = invalid;
            tick();
            bus.val_done = 1'b0; bus.val_invalid = 1'b0;
            budget = 10;
            while (!bus.parse_start && bus.busy && budget > 0) begin tick(); budget--; end
            if (bus.parse_start) begin
                for (int i = 0; i < nvals; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    bus.conv_valid = 1'b1; bus.conv_data = vals[i];
                    bus.parse_done = last_with_done && (i == nvals - 1);
                    tick();
                    bus.conv_valid = 1'b0; bus.parse_done = 1'b0;
                end
                if (!(last_with_done && nvals > 0)) begin
                    repeat ($urandom_range(0, 2)) tick();
                    bus.parse_done = 1'b1;
                    tick();
                    bus.parse_done = 1'b0;
                end
            end
        end
        tick(); tick();
        if (len == 0)             begin exp_err = 2; exp_n = 0;        exp_done = 1'b0; end
        else if (invalid)         begin exp_err = 1; exp_n = 0;        exp_done = 1'b0; end
        else if (nvals > MAX_NUMS) begin exp_err = 3; exp_n = MAX_NUMS; exp_done = 1'b0; end
        else                      begin exp_err = 0; exp_n = nvals;    exp_done = 1'b1; end
        chk("pkt_done", bus.done, exp_done);
        chk("pkt_error", bus.error, !exp_done);
        chk("pkt_err_code", bus.err_code, exp_err);
        chk("pkt_num_count", bus.num_count, exp_n);
        chk("pkt_busy", bus.busy, 0);
        chk("pkt_val_start_pulses", vs_cnt - vs0, (len != 0) ? 1 : 0);
        chk("pkt_parse_start_pulses", ps_cnt - ps0, (len != 0 && !invalid) ? 1 : 0);
        chk("pkt_write_count", wq_addr.size() - wq0, exp_n);
        for (int i = 0; i < exp_n && wq0 + i < wq_addr.size(); i++) begin
            chk("pkt_wr_addr", wq_addr[wq0 + i], i);
            chk("pkt_wr_data", wq_data[wq0 + i], vals[i]);
        end
    endtask

    initial begin
        int vs0, ps0;
        rst = 1'b1;
        bus.pkt_ready = 0; bus.pkt_length = 0; bus.abort = 0;
        bus.val_done = 0; bus.val_invalid = 0; bus.parse_done = 0;
        bus.conv_valid = 0; bus.conv_data = 0;
        tick(); tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_err_code", bus.err_code, 0);
        chk("rst_num_count", bus.num_count, 0);
        chk("rst_parse_length", bus.parse_length, 0);
        chk("rst_pulses", {bus.wr_en, bus.val_start, bus.parse_start, bus.parse_clear}, 0);
        rst = 1'b0;
        tick();

        // exact-cycle walk: length 5, clean, results 1, -7, 42 (last with parse_done)
        bus.pkt_ready = 1; bus.pkt_length = 16'd5;
        tick();
        bus.pkt_ready = 0;
        chk("t1_parse_clear_n1", bus.parse_clear, 1);
        chk("t1_parse_length_n1", bus.parse_length, 5);
        tick();
        chk("t1_val_start_n2", bus.val_start, 0);
        tick();
        chk("t1_val_start_n3", bus.val_start, 1);
        tick();
        bus.val_done = 1;
        tick();
        bus.val_done = 0;
        chk("t1_parse_start_m1", bus.parse_start, 0);
        tick();
        chk("t1_parse_start_m2", bus.parse_start, 1);
        bus.conv_valid = 1; bus.conv_data = 32'd1;
        tick();
        chk("t1_wr0", {bus.wr_en, 21'(bus.wr_addr), 11'(bus.num_count)}, {1'b1, 21'd0, 11'd1});
        chk("t1_wr0_data", bus.wr_data, 32'd1);
        bus.conv_data = 32'hFFFF_FFF9;
        tick();
        bus.conv_valid = 0;
        chk("t1_wr1", {bus.wr_en, 21'(bus.wr_addr), 11'(bus.num_count)}, {1'b1, 21'd1, 11'd2});
        chk("t1_wr1_data", bus.wr_data, 32'hFFFF_FFF9);
        tick();
        chk("t1_wr_idle", bus.wr_en, 0);
        bus.conv_valid = 1; bus.conv_data = 32'd42; bus.parse_done = 1;
        tick();
        bus.conv_valid = 0; bus.parse_done = 0;
        chk("t1_wr2", {bus.wr_en, 21'(bus.wr_addr), 11'(bus.num_count)}, {1'b1, 21'd2, 11'd3});
        chk("t1_wr2_data", bus.wr_data, 32'd42);
        chk("t1_done", {bus.done, bus.error, bus.busy}, 3'b100);
        chk("t1_err_code", bus.err_code, 0);

        // empty payload: error code 2 at N+3, no validator start
        vs0 = vs_cnt;
        bus.pkt_ready = 1; bus.pkt_length = 16'd0;
        tick();
        bus.pkt_ready = 0;
        chk("t2_done_falls", bus.done, 0);
        tick(); tick();
        chk("t2_error", bus.error, 1);
        chk("t2_err_code", bus.err_code, 2);
        tick();
        chk("t2_no_val_start", vs_cnt - vs0, 0);

        // invalid characters, overflow (five results into depth 4)
        run_packet(9, 1'b1, 0, 1'b0);
        for (int i = 0; i < 8; i++) vals[i] = $urandom;
        run_packet(12, 1'b0, 5, 1'b0);

        // abort in WAIT_PARSE after two writes
        bus.pkt_ready = 1; bus.pkt_length = 16'd3;
        tick();
        bus.pkt_ready = 0;
        for (int i = 0; i < 10 && !bus.parse_start; i++) begin
            if (i == 3) begin bus.val_done = 1; end
            tick();
            bus.val_done = 0;
        end
        chk("t5_in_parse", bus.parse_start, 1);
        bus.conv_valid = 1; bus.conv_data = 32'hAAAA_0001;
        tick();
        bus.conv_data = 32'hAAAA_0002;
        tick();
        bus.conv_valid = 0;
        chk("t5_two_written", bus.num_count, 2);
        bus.abort = 1;
        tick();
        bus.abort = 0;
        chk("t5_abort_idle", {bus.busy, bus.done, bus.error}, 3'b000);
        chk("t5_abort_clear", bus.parse_clear, 1);
        chk("t5_abort_count", bus.num_count, 0);
        chk("t5_abort_err", bus.err_code, 0);
        tick();
        chk("t5_clear_one_cycle", bus.parse_clear, 0);
        for (int i = 0; i < 8; i++) vals[i] = $urandom;
        run_packet(3, 1'b0, 2, 1'b1);

        // abort together with pkt_ready: packet dropped
        vs0 = vs_cnt;
        bus.pkt_ready = 1; bus.pkt_length = 16'd7; bus.abort = 1;
        tick();
        bus.pkt_ready = 0; bus.abort = 0;
        chk("t6_not_busy", bus.busy, 0);
        chk("t6_parse_clear", bus.parse_clear, 1);
        chk("t6_length_kept", bus.parse_length, 3);
        tick(); tick(); tick();
        chk("t6_no_val_start", vs_cnt - vs0, 0);

        // validator never answers
        bus.pkt_ready = 1; bus.pkt_length = 16'd2;
        tick();
        bus.pkt_ready = 0;
`ifdef ASCII_SEP_TIMEOUT_EN
        repeat (18) tick();
        chk("t7_not_yet", bus.error, 0);
        tick();
        chk("t7_timeout_error", bus.error, 1);
        chk("t7_timeout_code", bus.err_code, 4);
        chk("t7_timeout_clear", bus.parse_clear, 1);
`else
        repeat (1000) tick();
        chk("t7_still_busy", bus.busy, 1);
        chk("t7_no_error", bus.error, 0);
        bus.abort = 1;
        tick();
        bus.abort = 0;
        chk("t7_abort_out", bus.busy, 0);
`endif

        // randomized packets
        for (int p = 0; p < 10; p++) begin
            int len;
            len = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 300));
            for (int i = 0; i < 8; i++) vals[i] = $urandom;
            run_packet(len, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
